// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// timeout default and the store lane-steering functions.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_WAIT_DEFAULT = 16;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << addr_lo;
      2'b01:   lane_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{data[7:0]}};
      2'b01:   lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a bus read word and sign- or
// zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'b0, w_byte};
      F3_HU:   o_data = {16'b0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks legality and alignment, runs one
// bus transaction with a bounded wait, and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignFault,
  output logic        AccessFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  o_dbg_state
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  // Bus handshake: mem_req rises with addr/we/be/wdata already valid and all
  // of them stay stable until the cycle in which mem_ready is sampled high.
  lsu_state_e        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_read_data;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic              r_misalign;
  logic              r_access;
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;

  logic        w_access;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_start;
  logic [31:0] w_ext;

  always_comb begin
    w_access   = MemRead | MemWrite;
    w_illegal  = (MemRead & MemWrite)
               | (MemRead & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
               | (MemWrite & (funct3 >= 3'b011));
    w_misalign = ((funct3[1:0] == 2'b01) & ALUResult[0])
               | ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));
    w_start    = (r_state == ST_IDLE) & w_access & ~w_illegal & ~w_misalign;
    Stall      = w_start | (r_state == ST_REQ);
  end

  load_extend u_load_extend (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_read_data <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_misalign  <= 1'b0;
      r_access    <= 1'b0;
      r_is_load   <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_access   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              r_access <= 1'b1;
            end else if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_state     <= ST_REQ;
              r_wait      <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= MemWrite;
              r_mem_addr  <= {ALUResult[31:2], 2'b00};
              r_mem_be    <= lane_be(funct3, ALUResult[1:0]);
              r_mem_wdata <= MemWrite ? lane_wdata(funct3, WriteData) : 32'b0;
              r_is_load   <= MemRead;
              r_funct3    <= funct3;
              r_addr_lo   <= ALUResult[1:0];
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_load) r_read_data <= w_ext;
          end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
            // Bus never answered: give up and report it from DONE.
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_access  <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ReadData      = r_read_data;
  assign MisalignFault = r_misalign;
  assign AccessFault   = r_access;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_be        = r_mem_be;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the number of REQ-state cycles without mem_ready before an access is aborted with AccessFault.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset SHALL be synchronous and active-high.
REQ-004 MemRead  input  1  current instruction is a load.
REQ-005 MemWrite  input  1  current instruction is a store.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResult  input  32  byte address.
REQ-008 WriteData  input  32  store data (rs2).
REQ-009 ReadData  output  32  aligned, extended load data for the writeback result select.
REQ-010 Stall  output  1  core SHALL hold PC and pipeline state while high.
REQ-011 MisalignFault  output  1  one-cycle pulse: misaligned access.
REQ-012 AccessFault  output  1  one-cycle pulse: illegal request or bus timeout.
REQ-013 mem_req / mem_we  output  1 each  bus request, write strobe.
REQ-014 mem_addr  output  32  word address, {ALUResult[31:2],2'b00}.
REQ-015 mem_wdata  output  32; mem_be  output  4  lane-replicated data, byte enables.
REQ-016 mem_ready  input  1; mem_rdata  input  32  bus completion, read word.

Function
REQ-017 FSM states IDLE, REQ, DONE; access = MemRead|MemWrite in IDLE.
REQ-018 IDLE->REQ on legal, aligned access; Stall SHALL be high combinationally in that IDLE cycle and for every REQ cycle.
REQ-019 REQ: mem_req=1, addr/we/be/wdata registered at entry and held stable until mem_ready.
REQ-020 REQ->DONE on mem_ready; load captures extended mem_rdata into ReadData that edge.
REQ-021 REQ->DONE after MAX_WAIT cycles without mem_ready; AccessFault pulses in DONE; ReadData unchanged; no further bus activity.
REQ-022 DONE: Stall=0, mem_req=0, inputs ignored; DONE->IDLE unconditionally.
REQ-023 Alignment: H/HU need ALUResult[0]=0, W needs ALUResult[1:0]=00; misaligned -> MisalignFault pulse next cycle, no bus request, Stall low, ReadData unchanged.
REQ-024 Illegal: MemRead&MemWrite both high, load funct3 in {011,110,111}, or store funct3 >= 011 -> AccessFault pulse next cycle, no bus request, Stall low.
REQ-025 Store enables: SB be=0001<<addr[1:0], wdata={4{WriteData[7:0]}}; SH be=0011 (addr[1]=0) or 1100, wdata={2{WriteData[15:0]}}; SW be=1111, wdata=WriteData.
REQ-026 Loads drive mem_be as stores of same size; mem_wdata=0 on loads.
REQ-027 Extension: B/H sign-extend selected lane, BU/HU zero-extend, W unmodified.
REQ-028 ReadData SHALL hold its value until the next completed load.

Reset
REQ-029 On reset: state IDLE, wait counter 0, ReadData 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, both faults 0.
REQ-030 Reset during REQ SHALL drop mem_req next edge and discard the pending response.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, funct3 size/sign constants and MAX_WAIT default.
REQ-032 Combinational sub-module load_extend (lane select + sign/zero extension) SHALL be instantiated once.

Verification
REQ-033 LB addr 0x1003, mem_rdata 0x80FF_FF7F, ready after 2 cycles -> ReadData 0xFFFF_FF80, Stall high 3 cycles.
REQ-034 SH addr 0x2002, WriteData 0x0000_BEEF, ready immediately -> mem_be 1100, mem_wdata 0xBEEF_BEEF, mem_we 1.
REQ-035 LW addr 0x3001 -> MisalignFault one cycle, mem_req never high, ReadData unchanged.
REQ-036 LHU addr 0x4000, mem_ready never -> AccessFault after MAX_WAIT=16 REQ cycles, Stall then low.
REQ-037 LW in REQ, reset asserted, then mem_ready -> mem_req 0, ReadData 0, state IDLE.
